// File: rtl/mitigation_pkg.sv
// Shared encodings and configuration-address layout for the mitigation engine.
package mitigation_pkg;

  typedef enum logic [1:0] {
    ST_SAFE    = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_ARMED   = 2'd2
  } chan_state_e;

  localparam int unsigned MAX_CHANNELS   = 16;
  localparam int unsigned CHAN_SEL_WIDTH = 4;
  localparam int unsigned CFG_WORD_WIDTH = 32;
  localparam int unsigned STORE_WIDTH    = 64;

  // cfgAddress layout: [2] word, [3 +: idx] node, then type bit, then 4-bit channel
  localparam int unsigned ADDR_WORD_BIT  = 2;
  localparam int unsigned ADDR_NODE_LSB  = 3;

  function automatic int unsigned addr_type_bit(input int unsigned idx_width);
    return ADDR_NODE_LSB + idx_width;
  endfunction

  function automatic int unsigned addr_chan_lsb(input int unsigned idx_width);
    return ADDR_NODE_LSB + idx_width + 1;
  endfunction

endpackage

// File: rtl/mitigation_bitmap_ram.sv
// Per-node bitmap store: 32-bit word writes, full-width registered read (old data on collision).
module mitigation_bitmap_ram
  import mitigation_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      wrEn_i,
  input  logic [ADDR_WIDTH-1:0]     wrAddr_i,
  input  logic                      wrWord_i,
  input  logic [CFG_WORD_WIDTH-1:0] wrData_i,
  input  logic [ADDR_WIDTH-1:0]     rdAddr_i,
  output logic [DATA_WIDTH-1:0]     rdData_o
);

  logic [STORE_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0]  rdData_q;

  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      if (wrWord_i) begin
        mem_q[wrAddr_i][STORE_WIDTH-1:CFG_WORD_WIDTH] <= wrData_i;
      end else begin
        mem_q[wrAddr_i][CFG_WORD_WIDTH-1:0] <= wrData_i;
      end
    end
    rdData_q <= mem_q[rdAddr_i][DATA_WIDTH-1:0];
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/mitigation_engine.sv
// Per-channel interlock evaluation driving beam-permit outputs, with hold-off,
// auto-rearm, first-fault capture, saturating trip counts and status readback.
module mitigation_engine
  import mitigation_pkg::*;
#(
  parameter int unsigned INTERLOCKS_PER_NODE = 64,
  parameter int unsigned MITIGATION_COUNT    = 4,
  parameter int unsigned ACQ_INDEX_WIDTH     = 6,
  parameter int unsigned NODE_COUNT          = 64,
  parameter int unsigned HOLDOFF_WIDTH       = 10,
  parameter int unsigned HOLDOFF_CYCLES      = 1023,
  parameter int unsigned COUNT_WIDTH         = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cfgWrStrobe,
  input  logic [ACQ_INDEX_WIDTH+7:0]     cfgAddress,
  input  logic [31:0]                    cfgWrData,
  input  logic [MITIGATION_COUNT-1:0]    rearm,
  input  logic [MITIGATION_COUNT-1:0]    autoRearm,
  input  logic                           newDataStrobe,
  input  logic [ACQ_INDEX_WIDTH-1:0]     acqIndex,
  input  logic [INTERLOCKS_PER_NODE-1:0] inputState,
  input  logic [INTERLOCKS_PER_NODE-1:0] inputTransitions,
  input  logic [NODE_COUNT-1:0]          staleNodes,
  input  logic [3:0]                     statusSelect,
  output logic [1:0]                     statusState,
  output logic [ACQ_INDEX_WIDTH-1:0]     statusFaultNode,
  output logic [INTERLOCKS_PER_NODE-1:0] statusFaultBits,
  output logic [COUNT_WIDTH-1:0]         statusTripCount,
  output logic [MITIGATION_COUNT-1:0]    mitigationOutputs
);

  localparam int unsigned IPN      = INTERLOCKS_PER_NODE;
  localparam int unsigned AIW      = ACQ_INDEX_WIDTH;
  localparam int unsigned TYPE_BIT = addr_type_bit(AIW);
  localparam int unsigned CHAN_LSB = addr_chan_lsb(AIW);
  localparam logic [HOLDOFF_WIDTH-1:0] HOLDOFF_RELOAD = HOLDOFF_WIDTH'(HOLDOFF_CYCLES);

  logic                      cfgWord;
  logic                      cfgType;
  logic [AIW-1:0]            cfgNode;
  logic [CHAN_SEL_WIDTH-1:0] cfgChan;
  logic                      unused_cfgByte;

  assign cfgWord        = cfgAddress[ADDR_WORD_BIT];
  assign cfgNode        = cfgAddress[ADDR_NODE_LSB +: AIW];
  assign cfgType        = cfgAddress[TYPE_BIT];
  assign cfgChan        = cfgAddress[CHAN_LSB +: CHAN_SEL_WIDTH];
  assign unused_cfgByte = ^cfgAddress[1:0];

  logic           strb1_q;
  logic [AIW-1:0] node1_q;
  logic [AIW-1:0] node2_q;
  logic [IPN-1:0] state1_q;
  logic [IPN-1:0] trans1_q;

  // Inputs are delayed one stage to line up with the registered RAM read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      strb1_q  <= 1'b0;
      node1_q  <= '0;
      node2_q  <= '0;
      state1_q <= '0;
      trans1_q <= '0;
    end else begin
      strb1_q  <= newDataStrobe;
      node1_q  <= acqIndex;
      node2_q  <= node1_q;
      state1_q <= inputState;
      trans1_q <= inputTransitions;
    end
  end

  logic [1:0]             chState [MITIGATION_COUNT];
  logic [AIW-1:0]         chNode  [MITIGATION_COUNT];
  logic [IPN-1:0]         chBits  [MITIGATION_COUNT];
  logic [COUNT_WIDTH-1:0] chCount [MITIGATION_COUNT];
  logic [MITIGATION_COUNT-1:0] outs;

  for (genvar i = 0; i < MITIGATION_COUNT; i++) begin : g_chan
    logic           wrGood;
    logic           wrImp;
    logic [IPN-1:0] goodRd;
    logic [IPN-1:0] impRd;
    logic [IPN-1:0] hitBits;
    logic           bad1;

    assign wrGood  = cfgWrStrobe && (cfgChan == CHAN_SEL_WIDTH'(i)) && !cfgType;
    assign wrImp   = cfgWrStrobe && (cfgChan == CHAN_SEL_WIDTH'(i)) && cfgType;
    assign hitBits = ((state1_q ^ goodRd) | trans1_q) & impRd;
    assign bad1    = strb1_q && (|hitBits);

    mitigation_bitmap_ram #(
      .ADDR_WIDTH (AIW),
      .DATA_WIDTH (IPN)
    ) u_good_ram (
      .clk      (clk),
      .wrEn_i   (wrGood),
      .wrAddr_i (cfgNode),
      .wrWord_i (cfgWord),
      .wrData_i (cfgWrData),
      .rdAddr_i (acqIndex),
      .rdData_o (goodRd)
    );

    mitigation_bitmap_ram #(
      .ADDR_WIDTH (AIW),
      .DATA_WIDTH (IPN)
    ) u_imp_ram (
      .clk      (clk),
      .wrEn_i   (wrImp),
      .wrAddr_i (cfgNode),
      .wrWord_i (cfgWord),
      .wrData_i (cfgWrData),
      .rdAddr_i (acqIndex),
      .rdData_o (impRd)
    );

    logic [NODE_COUNT-1:0]    impLo_q, impHi_q;
    logic                     stale_q, rearm_q;
    logic                     bad_q;
    logic [IPN-1:0]           bits_q;
    chan_state_e              state_q, state_d;
    logic [HOLDOFF_WIDTH-1:0] timer_q, timer_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic                     capEn_q, capEn_d;
    logic [AIW-1:0]           capNode_q, capNode_d;
    logic [IPN-1:0]           capBits_q, capBits_d;
    logic                     out_q, out_d;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        impLo_q   <= '0;
        impHi_q   <= '0;
        stale_q   <= 1'b0;
        rearm_q   <= 1'b0;
        bad_q     <= 1'b0;
        bits_q    <= '0;
        state_q   <= ST_SAFE;
        timer_q   <= '0;
        count_q   <= '0;
        capEn_q   <= 1'b0;
        capNode_q <= '0;
        capBits_q <= '0;
        out_q     <= 1'b0;
      end else begin
        if (wrImp) begin
          if (cfgWord) impHi_q[cfgNode] <= |cfgWrData;
          else         impLo_q[cfgNode] <= |cfgWrData;
        end
        // rearm shares the single register stage used by the stale check
        stale_q   <= |(staleNodes & (impLo_q | impHi_q));
        rearm_q   <= rearm[i];
        bad_q     <= bad1;
        bits_q    <= hitBits;
        state_q   <= state_d;
        timer_q   <= timer_d;
        count_q   <= count_d;
        capEn_q   <= capEn_d;
        capNode_q <= capNode_d;
        capBits_q <= capBits_d;
        out_q     <= out_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      count_d   = count_q;
      capEn_d   = capEn_q;
      capNode_d = capNode_q;
      capBits_d = capBits_q;
      if (bad_q) begin
        state_d = ST_HOLDOFF;
        timer_d = HOLDOFF_RELOAD;
      end else begin
        unique case (state_q)
          ST_SAFE:    if (rearm_q && !stale_q) state_d = ST_ARMED;
          // Leaving on the edge the timer reaches zero keeps HOLDOFF exactly HOLDOFF_CYCLES long.
          ST_HOLDOFF: begin
            if (timer_q <= HOLDOFF_WIDTH'(1)) begin
              timer_d = '0;
              state_d = (autoRearm[i] && !stale_q) ? ST_ARMED : ST_SAFE;
            end else begin
              timer_d = timer_q - 1'b1;
            end
          end
          ST_ARMED:   if (stale_q) state_d = ST_SAFE;
          default:    state_d = ST_SAFE;
        endcase
      end
      if ((state_q == ST_ARMED) && (state_d != ST_ARMED) && (count_q != '1)) begin
        count_d = count_q + 1'b1;
      end
      if (bad_q && capEn_q) begin
        capEn_d   = 1'b0;
        capNode_d = node2_q;
        capBits_d = bits_q;
      end
      if ((state_q != ST_ARMED) && (state_d == ST_ARMED)) capEn_d = 1'b1;
      out_d = (state_d == ST_ARMED);
    end

    assign chState[i] = state_q;
    assign chNode[i]  = capNode_q;
    assign chBits[i]  = capBits_q;
    assign chCount[i] = count_q;
    assign outs[i]    = out_q;
  end

  always_comb begin
    statusState     = '0;
    statusFaultNode = '0;
    statusFaultBits = '0;
    statusTripCount = '0;
    for (int unsigned c = 0; c < MITIGATION_COUNT; c++) begin
      if (statusSelect == CHAN_SEL_WIDTH'(c)) begin
        statusState     = chState[c];
        statusFaultNode = chNode[c];
        statusFaultBits = chBits[c];
        statusTripCount = chCount[c];
      end
    end
  end

  assign mitigationOutputs = outs;

endmodule

// File: tb/tb_mitigation_engine.sv
// Directed bench for mitigation_engine: arming, faults, hold-off, stale trips, capture, saturation.
module tb_mitigation_engine;

  logic        clk;
  logic        reset_n;
  logic        cfgWrStrobe;
  logic [13:0] cfgAddress;
  logic [31:0] cfgWrData;
  logic [3:0]  rearm;
  logic [3:0]  autoRearm;
  logic        newDataStrobe;
  logic [5:0]  acqIndex;
  logic [63:0] inputState;
  logic [63:0] inputTransitions;
  logic [63:0] staleNodes;
  logic [3:0]  statusSelect;
  logic [1:0]  statusState;
  logic [5:0]  statusFaultNode;
  logic [63:0] statusFaultBits;
  logic [1:0]  statusTripCount;
  logic [3:0]  mitigationOutputs;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  mitigation_engine #(
    .INTERLOCKS_PER_NODE (64),
    .MITIGATION_COUNT    (4),
    .ACQ_INDEX_WIDTH     (6),
    .NODE_COUNT          (64),
    .HOLDOFF_WIDTH       (10),
    .HOLDOFF_CYCLES      (8),
    .COUNT_WIDTH         (2)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cfgWrStrobe       (cfgWrStrobe),
    .cfgAddress        (cfgAddress),
    .cfgWrData         (cfgWrData),
    .rearm             (rearm),
    .autoRearm         (autoRearm),
    .newDataStrobe     (newDataStrobe),
    .acqIndex          (acqIndex),
    .inputState        (inputState),
    .inputTransitions  (inputTransitions),
    .staleNodes        (staleNodes),
    .statusSelect      (statusSelect),
    .statusState       (statusState),
    .statusFaultNode   (statusFaultNode),
    .statusFaultBits   (statusFaultBits),
    .statusTripCount   (statusTripCount),
    .mitigationOutputs (mitigationOutputs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] mkaddr(input logic [3:0] ch, input logic typ,
                                         input logic [5:0] node, input logic word);
    return {ch, typ, node, word, 2'b00};
  endfunction

  task automatic cfg_write(input logic [3:0] ch, input logic typ, input logic [5:0] node,
                           input logic word, input logic [31:0] data);
    cfgWrStrobe = 1'b1;
    cfgAddress  = mkaddr(ch, typ, node, word);
    cfgWrData   = data;
    @(negedge clk);
    cfgWrStrobe = 1'b0;
  endtask

  task automatic send_record(input logic [5:0] node, input logic [63:0] st, input logic [63:0] tr);
    newDataStrobe    = 1'b1;
    acqIndex         = node;
    inputState       = st;
    inputTransitions = tr;
    @(negedge clk);
    newDataStrobe    = 1'b0;
    inputState       = '0;
    inputTransitions = '0;
  endtask

  task automatic pulse_rearm(input int unsigned ch);
    rearm     = '0;
    rearm[ch] = 1'b1;
    @(negedge clk);
    rearm     = '0;
  endtask

  task automatic wait_state(input string tag, input logic [1:0] exp, input int unsigned budget);
    int unsigned k = 0;
    while (statusState !== exp && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(statusState), 64'(exp));
  endtask

  initial begin
    reset_n = 1'b0; cfgWrStrobe = 1'b0; cfgAddress = '0; cfgWrData = '0;
    rearm = '0; autoRearm = '0; newDataStrobe = 1'b0; acqIndex = '0;
    inputState = '0; inputTransitions = '0; staleNodes = '0; statusSelect = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(mitigationOutputs), 64'h0);
    check("reset_state",   64'(statusState), 64'h0);
    check("reset_count",   64'(statusTripCount), 64'h0);
    check("reset_node",    64'(statusFaultNode), 64'h0);
    check("reset_bits",    statusFaultBits, 64'h0);
    reset_n = 1'b1;

    for (int unsigned ch = 0; ch < 4; ch++)
      for (int unsigned n = 0; n < 2; n++)
        for (int unsigned t = 0; t < 2; t++)
          for (int unsigned w = 0; w < 2; w++)
            cfg_write(4'(ch), 1'(t), (n == 0) ? 6'd3 : 6'd5, 1'(w), 32'h0);
    cfg_write(4'd0, 1'b1, 6'd5, 1'b0, 32'h3);

    // Arm channel 0, then fault node 5 bit 0
    pulse_rearm(0);
    check("rearm_latency", 64'(mitigationOutputs), 64'h0);
    @(negedge clk);
    check("armed_output", 64'(mitigationOutputs), 64'h1);
    check("armed_state",  64'(statusState), 64'h2);
    send_record(6'd5, 64'h1, 64'h0);
    check("fault_n0_out", 64'(mitigationOutputs), 64'h1);
    @(negedge clk);
    check("fault_n1_out", 64'(mitigationOutputs), 64'h1);
    @(negedge clk);
    check("fault_n2_out",   64'(mitigationOutputs), 64'h0);
    check("fault_state",    64'(statusState), 64'h1);
    check("fault_node",     64'(statusFaultNode), 64'h5);
    check("fault_bits",     statusFaultBits, 64'h1);
    check("fault_count",    64'(statusTripCount), 64'h1);

    // Hold-off without auto-rearm: rearm ignored, 8 cycles then SAFE
    pulse_rearm(0);
    check("rearm_ignored_holdoff", 64'(statusState), 64'h1);
    repeat (6) @(negedge clk);
    check("holdoff_last_cycle", 64'(statusState), 64'h1);
    @(negedge clk);
    check("holdoff_to_safe",     64'(statusState), 64'h0);
    check("holdoff_safe_output", 64'(mitigationOutputs), 64'h0);
    pulse_rearm(0);
    @(negedge clk);
    check("rearm_from_safe", 64'(statusState), 64'h2);

    // Auto-rearm with a re-trigger four cycles into hold-off
    autoRearm = 4'b0001;
    send_record(6'd5, 64'h0, 64'h2);
    repeat (3) @(negedge clk);
    send_record(6'd5, 64'h1, 64'h0);
    check("auto_first_holdoff", 64'(statusState), 64'h1);
    check("auto_count",         64'(statusTripCount), 64'h2);
    repeat (2) @(negedge clk);
    repeat (7) @(negedge clk);
    check("holdoff_reload", 64'(statusState), 64'h1);
    @(negedge clk);
    check("auto_rearmed_state", 64'(statusState), 64'h2);
    check("auto_rearmed_out",   64'(mitigationOutputs), 64'h1);
    check("capture_kept_bits",  statusFaultBits, 64'h2);
    check("capture_kept_node",  64'(statusFaultNode), 64'h5);
    check("auto_count_kept",    64'(statusTripCount), 64'h2);
    autoRearm = 4'b0000;

    // Node 3 made important through word 1 only; stale trip while ARMED
    cfg_write(4'd0, 1'b1, 6'd3, 1'b1, 32'h8000_0000);
    cfg_write(4'd0, 1'b1, 6'd3, 1'b0, 32'h0);
    staleNodes[3] = 1'b1;
    @(negedge clk);
    check("stale_reg_delay", 64'(mitigationOutputs), 64'h1);
    @(negedge clk);
    check("stale_trip_out",   64'(mitigationOutputs), 64'h0);
    check("stale_trip_state", 64'(statusState), 64'h0);
    check("stale_trip_count", 64'(statusTripCount), 64'h3);
    pulse_rearm(0);
    @(negedge clk);
    check("rearm_refused_stale", 64'(statusState), 64'h0);

    // Fault and rearm meeting at the state machine: fault wins
    staleNodes = '0;
    send_record(6'd3, 64'h8000_0000_0000_0000, 64'h0);
    pulse_rearm(0);
    check("coincide_no_arm", 64'(mitigationOutputs), 64'h0);
    @(negedge clk);
    check("coincide_holdoff", 64'(statusState), 64'h1);

    // Writes to channel 15 must not reach any implemented channel
    cfg_write(4'd15, 1'b1, 6'd5, 1'b0, 32'hFFFF_FFFF);
    send_record(6'd5, 64'hFFFF_FFFF, 64'h0);
    repeat (2) @(negedge clk);
    for (int unsigned ch = 1; ch < 4; ch++) begin
      statusSelect = 4'(ch);
      #1;
      check($sformatf("chan15_isolated_ch%0d", ch), 64'(statusState), 64'h0);
    end
    statusSelect = 4'd4;
    #1;
    check("sel4_state", 64'(statusState), 64'h0);
    check("sel4_count", 64'(statusTripCount), 64'h0);
    statusSelect = 4'd15;
    #1;
    check("sel15_count", 64'(statusTripCount), 64'h0);
    statusSelect = 4'd0;
    #1;
    check("sel0_count", 64'(statusTripCount), 64'h3);

    // Saturated counter holds; reset mid hold-off
    @(negedge clk);
    wait_state("return_to_safe", 2'd0, 20);
    pulse_rearm(0);
    @(negedge clk);
    check("rearm_before_sat", 64'(statusState), 64'h2);
    send_record(6'd5, 64'h1, 64'h0);
    repeat (2) @(negedge clk);
    check("sat_trip_state", 64'(statusState), 64'h1);
    check("count_saturated", 64'(statusTripCount), 64'h3);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_state", 64'(statusState), 64'h0);
    check("midreset_count", 64'(statusTripCount), 64'h0);
    check("midreset_out",   64'(mitigationOutputs), 64'h0);
    check("midreset_node",  64'(statusFaultNode), 64'h0);
    check("midreset_bits",  statusFaultBits, 64'h0);
    reset_n = 1'b1;

    // Important flags cleared by reset, bitmap contents retained
    staleNodes[3] = 1'b1;
    pulse_rearm(0);
    @(negedge clk);
    check("flags_cleared_arm", 64'(statusState), 64'h2);
    send_record(6'd5, 64'h1, 64'h0);
    repeat (2) @(negedge clk);
    check("ram_retained_fault", 64'(statusState), 64'h1);
    staleNodes = '0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
